gate_result_checker: RTL and testbench

- Downstream stage of the gates block. Samples a/b and the gate outputs (c_and, d_or, e_xor) one vector per accepted transfer.
- Recomputes the expected AND/OR/XOR values and compares them with the sampled outputs.
- Counts accepted vectors and mismatching vectors over a programmed run, then reports done/pass.
- Serves as a self-checking scoreboard for gate-level benches and on-chip BIST of the gates stage.

---
 rtl/gate_result_checker.sv | 127 ++++++++++++
 tb/tb_gate_result_checker.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/gate_result_checker.sv
// Scoreboard for the gates stage: recomputes AND/OR/XOR per accepted vector, counts vectors and mismatches over a run.
// Latency: counters/last_err update the cycle after the accepting edge; done/pass the cycle after the final transfer.
// Backpressure: in_ready is high only in RUN; optional GATE_CHK_FIRST_ERR_EN adds first_err_idx/first_err_code.
module gate_result_checker #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             a,
    input  logic             b,
    input  logic             c_and,
    input  logic             d_or,
    input  logic             e_xor,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [2:0]       last_err
`ifdef GATE_CHK_FIRST_ERR_EN
    ,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [2:0]       first_err_code
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] target;
    logic [2:0]       mism;
    logic [CNT_W-1:0] vec_next;
    logic [CNT_W-1:0] err_next;

    always_comb begin
        mism     = {a ^ b, a | b, a & b} ^ {e_xor, d_or, c_and};
        vec_next = vec_cnt + 1'b1;
        err_next = err_cnt;
        // Saturate rather than wrap so a full-error run never reads as clean.
        if (mism != 3'b000 && err_cnt != {CNT_W{1'b1}}) begin
            err_next = err_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            target         <= '0;
            in_ready       <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            vec_cnt        <= '0;
            err_cnt        <= '0;
            last_err       <= 3'b000;
`ifdef GATE_CHK_FIRST_ERR_EN
            first_err_idx  <= '0;
            first_err_code <= 3'b000;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        target         <= num_vec;
                        vec_cnt        <= '0;
                        err_cnt        <= '0;
                        last_err       <= 3'b000;
`ifdef GATE_CHK_FIRST_ERR_EN
                        first_err_idx  <= '0;
                        first_err_code <= 3'b000;
`endif
                        if (num_vec != '0) begin
                            state    <= S_RUN;
                            in_ready <= 1'b1;
                            busy     <= 1'b1;
                            done     <= 1'b0;
                            pass     <= 1'b0;
                        end else begin
                            state    <= S_DONE;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            pass     <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (in_valid) begin
                        vec_cnt  <= vec_next;
                        err_cnt  <= err_next;
                        last_err <= mism;
`ifdef GATE_CHK_FIRST_ERR_EN
                        // err_cnt never returns to zero within a run, so zero marks the first miss.
                        if (mism != 3'b000 && err_cnt == '0) begin
                            first_err_idx  <= vec_cnt;
                            first_err_code <= mism;
                        end
`endif
                        if (vec_next == target) begin
                            state    <= S_DONE;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            pass     <= (err_next == '0);
                        end
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    pass     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_result_checker.sv
// Bench for gate_result_checker: directed runs, a per-cycle behavioural model, and literal spot checks.
module tb_gate_result_checker;

    localparam int CW   = 8;
    localparam int MAXV = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] num_vec = '0;
    logic          in_valid = 1'b0;
    logic          a = 1'b0, b = 1'b0, c_and = 1'b0, d_or = 1'b0, e_xor = 1'b0;
    logic          in_ready, busy, done, pass;
    logic [CW-1:0] vec_cnt, err_cnt;
    logic [2:0]    last_err;
`ifdef GATE_CHK_FIRST_ERR_EN
    logic [CW-1:0] first_err_idx;
    logic [2:0]    first_err_code;
    logic [1:0]    first_err_idx2;
    logic [2:0]    first_err_code2;
`endif

    // Narrow instance for the CNT_W=2 saturation case
    logic       start2 = 1'b0;
    logic [1:0] num_vec2 = '0;
    logic       in_valid2 = 1'b0;
    logic       a2 = 1'b0, b2 = 1'b0, c2 = 1'b0, d2 = 1'b0, e2 = 1'b0;
    logic       in_ready2, busy2, done2, pass2;
    logic [1:0] vec_cnt2, err_cnt2;
    logic [2:0] last_err2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    gate_result_checker #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_vec(num_vec),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_and(c_and), .d_or(d_or), .e_xor(e_xor),
        .busy(busy), .done(done), .pass(pass),
        .vec_cnt(vec_cnt), .err_cnt(err_cnt), .last_err(last_err)
`ifdef GATE_CHK_FIRST_ERR_EN
        , .first_err_idx(first_err_idx), .first_err_code(first_err_code)
`endif
    );

    gate_result_checker #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .num_vec(num_vec2),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .c_and(c2), .d_or(d2), .e_xor(e2),
        .busy(busy2), .done(done2), .pass(pass2),
        .vec_cnt(vec_cnt2), .err_cnt(err_cnt2), .last_err(last_err2)
`ifdef GATE_CHK_FIRST_ERR_EN
        , .first_err_idx(first_err_idx2), .first_err_code(first_err_code2)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0=idle, 1=collecting vectors, 2=finished
    int m_phase = 0, m_target = 0, m_vec = 0, m_err = 0, m_last = 0;
    int m_fidx = 0, m_fcode = 0;
    bit m_seen = 0;

    always @(posedge clk or negedge rst_n) begin
        int s, mm;
        if (!rst_n) begin
            m_phase = 0; m_target = 0; m_vec = 0; m_err = 0; m_last = 0;
            m_fidx = 0; m_fcode = 0; m_seen = 0;
        end else if (m_phase == 1) begin
            if (in_valid) begin
                s  = int'(a) + int'(b);
                mm = (int'(c_and) != int'(s == 2)) * 1
                   + (int'(d_or)  != int'(s >= 1)) * 2
                   + (int'(e_xor) != int'(s == 1)) * 4;
                if (mm != 0 && !m_seen) begin
                    m_seen = 1; m_fidx = m_vec; m_fcode = mm;
                end
                m_vec  = m_vec + 1;
                m_last = mm;
                if (mm != 0 && m_err < MAXV) m_err = m_err + 1;
                if (m_vec == m_target) m_phase = 2;
            end
        end else if (start) begin
            m_target = int'(num_vec);
            m_vec = 0; m_err = 0; m_last = 0; m_fidx = 0; m_fcode = 0; m_seen = 0;
            m_phase = (num_vec != 0) ? 1 : 2;
        end
    end

    always @(negedge clk) begin
        chk("in_ready", in_ready, m_phase == 1);
        chk("busy", busy, m_phase == 1);
        chk("done", done, m_phase == 2);
        chk("pass", pass, m_phase == 2 && m_err == 0);
        chk("vec_cnt", vec_cnt, m_vec);
        chk("err_cnt", err_cnt, m_err);
        chk("last_err", last_err, m_last);
`ifdef GATE_CHK_FIRST_ERR_EN
        chk("first_err_idx", first_err_idx, m_fidx);
        chk("first_err_code", first_err_code, m_fcode);
`endif
    end

    // All tasks are entered at a falling edge and return at a falling edge.
    task automatic start_run(input int n);
        start = 1'b1; num_vec = CW'(n);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drive(input bit v, input bit av, input bit bv, input bit cv, input bit dv, input bit ev);
        in_valid = v; a = av; b = bv; c_and = cv; d_or = dv; e_xor = ev;
        @(negedge clk);
    endtask

    task automatic good(input bit av, input bit bv);
        drive(1'b1, av, bv, av & bv, av | bv, av ^ bv);
    endtask

    initial begin
        int pat[8];
        pat = '{1, 0, 0, 1, 1, 0, 1, 1};

        repeat (2) @(negedge clk);
        chk("rst in_ready", in_ready, 0);
        chk("rst done", done, 0);
        chk("rst pass", pass, 0);
        chk("rst vec_cnt", vec_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Zero-length run from IDLE
        start_run(0);
        chk("t5 done", done, 1);
        chk("t5 pass", pass, 1);
        chk("t5 vec_cnt", vec_cnt, 0);
        chk("t5 in_ready", in_ready, 0);

        // Four correct vectors
        start_run(4);
        chk("t1 in_ready", in_ready, 1);
        good(0, 0); good(0, 1); good(1, 0); good(1, 1);
        in_valid = 1'b0;
        chk("t1 vec_cnt", vec_cnt, 4);
        chk("t1 err_cnt", err_cnt, 0);
        chk("t1 done", done, 1);
        chk("t1 pass", pass, 1);
        @(negedge clk);
        chk("t1 in_ready after", in_ready, 0);

        // One wrong AND on the second vector
        start_run(3);
        good(0, 0);
        drive(1'b1, 1, 1, 0, 1, 0);
        chk("t2 last_err", last_err, 3'b001);
        chk("t2 err_cnt", err_cnt, 1);
        good(1, 0);
        in_valid = 1'b0;
        chk("t2 done", done, 1);
        chk("t2 pass", pass, 0);
        chk("t2 last_err clean", last_err, 0);
`ifdef GATE_CHK_FIRST_ERR_EN
        chk("t2 first_err_idx", first_err_idx, 1);
        chk("t2 first_err_code", first_err_code, 3'b001);
`endif

        // Saturation point on the 2-bit instance
        start2 = 1'b1; num_vec2 = 2'd3;
        @(negedge clk);
        start2 = 1'b0;
        in_valid2 = 1'b1; c2 = 1'b1;
        repeat (3) @(negedge clk);
        in_valid2 = 1'b0;
        chk("t3 narrow err_cnt", err_cnt2, 3);
        chk("t3 narrow vec_cnt", vec_cnt2, 3);
        chk("t3 narrow done", done2, 1);
        chk("t3 narrow pass", pass2, 0);
        chk("t3 narrow last_err", last_err2, 3'b001);

        // 255 wrong vectors on the full-width instance (XOR wrong)
        start_run(255);
        in_valid = 1'b1; a = 1; b = 1; c_and = 1; d_or = 1; e_xor = 1;
        repeat (255) @(negedge clk);
        in_valid = 1'b0;
        chk("t3 err_cnt", err_cnt, 255);
        chk("t3 vec_cnt", vec_cnt, 255);
        chk("t3 last_err", last_err, 3'b100);
        chk("t3 done", done, 1);

        // Stalling valid pattern with an ignored mid-run start
        start_run(5);
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin start = 1'b1; num_vec = 8'd7; end
            else start = 1'b0;
            drive(pat[i] != 0, i[0], i[1], i[0] & i[1], i[0] | i[1], i[0] ^ i[1]);
        end
        start = 1'b0; in_valid = 1'b0;
        chk("t4 vec_cnt", vec_cnt, 5);
        chk("t4 done", done, 1);
        chk("t4 pass", pass, 1);

        // Asynchronous reset mid-run
        start_run(6);
        good(0, 1); good(1, 1);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t6 rst in_ready", in_ready, 0);
        chk("t6 rst busy", busy, 0);
        chk("t6 rst vec_cnt", vec_cnt, 0);
        chk("t6 rst last_err", last_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_run(2);
        good(1, 1); good(0, 0);
        in_valid = 1'b0;
        chk("t6 vec_cnt", vec_cnt, 2);
        chk("t6 pass", pass, 1);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
